// File: rtl/tdp_bram_be.sv
// True dual-port block RAM with per-byte write enables, 1/2-cycle read latency,
// selectable read-during-write mode and A-priority write-collision handling.
// Optional collision counter: define TDP_BRAM_BE_COLL_CNT_EN.
module tdp_bram_be #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enA,
  input  logic                    i_weA,
  input  logic [DATA_WIDTH/8-1:0] i_beA,
  input  logic [ADDR_WIDTH-1:0]   i_addrA,
  input  logic [DATA_WIDTH-1:0]   i_dinA,
  output logic [DATA_WIDTH-1:0]   o_doutA,
  output logic                    o_validA,
  input  logic                    i_enB,
  input  logic                    i_weB,
  input  logic [DATA_WIDTH/8-1:0] i_beB,
  input  logic [ADDR_WIDTH-1:0]   i_addrB,
  input  logic [DATA_WIDTH-1:0]   i_dinB,
  output logic [DATA_WIDTH-1:0]   o_doutB,
  output logic                    o_validB,
  output logic                    o_collision,
  output logic [CNT_WIDTH-1:0]    o_coll_cnt
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_data_width
    $error("tdp_bram_be: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_read_latency
    $error("tdp_bram_be: READ_LATENCY must be 1 or 2");
  end

  function automatic logic [DATA_WIDTH-1:0] f_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         be,
    input logic                  we
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int k = 0; k < NB; k++) begin
      if (we && be[k]) begin
        res[8*k +: 8] = new_word[8*k +: 8];
      end
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_wrA, w_wrB, w_coll;
  logic [DATA_WIDTH-1:0] w_oldA, w_oldB, w_rdA, w_rdB;
  logic                  r_s1_validA, r_s1_validB, r_coll;
  logic [DATA_WIDTH-1:0] r_s1_dataA, r_s1_dataB;

  assign w_wrA  = i_enA & i_weA;
  assign w_wrB  = i_enB & i_weB;
  assign w_coll = w_wrA & w_wrB & (i_addrA == i_addrB);
  assign w_oldA = r_mem[i_addrA];
  assign w_oldB = r_mem[i_addrB];
  // Cross-port readers always see the stored (pre-write) word; only the own write can be forwarded.
  assign w_rdA  = (WRITE_MODE == 1) ? f_merge(w_oldA, i_dinA, i_beA, w_wrA) : w_oldA;
  assign w_rdB  = (WRITE_MODE == 1) ? f_merge(w_oldB, i_dinB, i_beB, w_wrB) : w_oldB;

  // Port A writes are issued after port B so A wins any byte both ports enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (i_rst_n) begin
      for (int k = 0; k < NB; k++) begin
        if (w_wrB && i_beB[k]) begin
          r_mem[i_addrB][8*k +: 8] <= i_dinB[8*k +: 8];
        end
      end
      for (int k = 0; k < NB; k++) begin
        if (w_wrA && i_beA[k]) begin
          r_mem[i_addrA][8*k +: 8] <= i_dinA[8*k +: 8];
        end
      end
    end
  end

  // First read stage and collision flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_validA <= 1'b0;
      r_s1_validB <= 1'b0;
      r_s1_dataA  <= {DATA_WIDTH{1'b0}};
      r_s1_dataB  <= {DATA_WIDTH{1'b0}};
      r_coll      <= 1'b0;
    end else begin
      r_s1_validA <= i_enA;
      r_s1_validB <= i_enB;
      if (i_enA) begin
        r_s1_dataA <= w_rdA;
      end
      if (i_enB) begin
        r_s1_dataB <= w_rdB;
      end
      r_coll <= w_coll;
    end
  end

  if (READ_LATENCY == 2) begin : g_rl2
    logic                  r_s2_validA, r_s2_validB;
    logic [DATA_WIDTH-1:0] r_s2_dataA, r_s2_dataB;

    // Output pipeline stage; data only advances behind a valid stage-1 entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_s2_validA <= 1'b0;
        r_s2_validB <= 1'b0;
        r_s2_dataA  <= {DATA_WIDTH{1'b0}};
        r_s2_dataB  <= {DATA_WIDTH{1'b0}};
      end else begin
        r_s2_validA <= r_s1_validA;
        r_s2_validB <= r_s1_validB;
        if (r_s1_validA) begin
          r_s2_dataA <= r_s1_dataA;
        end
        if (r_s1_validB) begin
          r_s2_dataB <= r_s1_dataB;
        end
      end
    end

    assign o_doutA  = r_s2_dataA;
    assign o_doutB  = r_s2_dataB;
    assign o_validA = r_s2_validA;
    assign o_validB = r_s2_validB;
  end else begin : g_rl1
    assign o_doutA  = r_s1_dataA;
    assign o_doutB  = r_s1_dataB;
    assign o_validA = r_s1_validA;
    assign o_validB = r_s1_validB;
  end

  assign o_collision = r_coll;

`ifdef TDP_BRAM_BE_COLL_CNT_EN
  logic [CNT_WIDTH-1:0] r_coll_cnt;

  // Saturating count, updated on the same edge that raises o_collision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_coll_cnt <= {CNT_WIDTH{1'b0}};
    end else if (w_coll && (r_coll_cnt != {CNT_WIDTH{1'b1}})) begin
      r_coll_cnt <= r_coll_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_coll_cnt = r_coll_cnt;
`else
  assign o_coll_cnt = {CNT_WIDTH{1'b0}};
`endif

endmodule
